// File: rtl/ram_sdp_pkg.sv
// Shared types, default parameters and the byte-parity helper for the
// parametrised simple dual-port RAM. The parity helper is only used when the
// design is built with RAM_SDP_PARITY_EN defined.
package ram_sdp_pkg;

   // Controller states: INIT clears the array word by word, READY serves requests
   typedef enum logic {
      INIT,
      READY
   } state_t;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_DEPTH      = 32;
   localparam int DEFAULT_RD_LAT     = 1;
   localparam int DEFAULT_RDW_MODE   = 0;

   // The parity helper works on a fixed maximum width; narrower words are
   // zero-padded, and the padding bytes always have a parity of zero
   localparam int PARITY_MAX_WIDTH = 512;
   localparam int PARITY_MAX_BYTES = PARITY_MAX_WIDTH / 8;

   // Even-parity bit per byte: bit k is the XOR of data[8k+7:8k]
   function automatic logic [PARITY_MAX_BYTES-1:0] byte_parity(
      input logic [PARITY_MAX_WIDTH-1:0] data
   );
      logic [PARITY_MAX_BYTES-1:0] par;
      par = '0;
      for (int k = 0; k < PARITY_MAX_BYTES; k++) begin
         par[k] = ^data[8*k +: 8];
      end
      return par;
   endfunction

endpackage

// File: rtl/ram_sdp_param_if.sv
// Request/response bundle of the parametrised simple dual-port RAM.
// RAM_SDP_PARITY_EN adds wr_par_inj (error injection) and rd_err.
interface ram_sdp_param_if
   import ram_sdp_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) ();

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int NUM_BYTES  = DATA_WIDTH / 8;

   logic                  wr_enb;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [NUM_BYTES-1:0]  wr_be;
   logic                  rd_enb;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  init_done;
`ifdef RAM_SDP_PARITY_EN
   logic                  wr_par_inj;
   logic                  rd_err;
`endif

   // Requester side
   modport master (
      output wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
`ifdef RAM_SDP_PARITY_EN
      output wr_par_inj,
      input  rd_err,
`endif
      input  rd_data, rd_valid, init_done
   );

   // RAM side
   modport slave (
      input  wr_enb, wr_addr, wr_data, wr_be, rd_enb, rd_addr,
`ifdef RAM_SDP_PARITY_EN
      input  wr_par_inj,
      output rd_err,
`endif
      output rd_data, rd_valid, init_done
   );

endinterface

// File: rtl/ram_sdp_rd_pipe.sv
// Read-result pipeline: RD_LAT register stages carrying valid and data (and
// the parity error flag when RAM_SDP_PARITY_EN is defined). Data stages only
// load on a valid entry, so the output holds its last result between reads.
module ram_sdp_rd_pipe
   import ram_sdp_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int RD_LAT     = DEFAULT_RD_LAT
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef RAM_SDP_PARITY_EN
   input  logic                  err_i,
   output logic                  err_o,
`endif
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [RD_LAT-1:0]     valid_q;
   logic [DATA_WIDTH-1:0] data_q [RD_LAT];
`ifdef RAM_SDP_PARITY_EN
   logic [RD_LAT-1:0]     err_q;
`endif

   // Shift results down the pipe; reset flushes every stage to zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            data_q[s] <= '0;
         end
`ifdef RAM_SDP_PARITY_EN
         err_q <= '0;
`endif
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) begin
            data_q[0] <= data_i;
`ifdef RAM_SDP_PARITY_EN
            err_q[0] <= err_i;
`endif
         end
         for (int s = 1; s < RD_LAT; s++) begin
            valid_q[s] <= valid_q[s-1];
            if (valid_q[s-1]) begin
               data_q[s] <= data_q[s-1];
`ifdef RAM_SDP_PARITY_EN
               err_q[s] <= err_q[s-1];
`endif
            end
         end
      end
   end

   assign valid_o = valid_q[RD_LAT-1];
   assign data_o  = data_q[RD_LAT-1];
`ifdef RAM_SDP_PARITY_EN
   assign err_o   = err_q[RD_LAT-1];
`endif

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised simple dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write policy and a counter-driven clear after reset.
// Define RAM_SDP_PARITY_EN to store an even-parity bit per byte, report
// mismatches on rd_err and allow parity error injection via wr_par_inj.
module ram_sdp_param
   import ram_sdp_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int RD_LAT     = DEFAULT_RD_LAT,
   parameter int RDW_MODE   = DEFAULT_RDW_MODE
) (
   input logic           clk,
   input logic           rst,
   ram_sdp_param_if.slave bus
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int NUM_BYTES  = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
      $error("ram_sdp_param: DATA_WIDTH must be a positive multiple of 8");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("ram_sdp_param: DEPTH must be a power of 2 and at least 2");
   end
   if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_lat
      $error("ram_sdp_param: RD_LAT must be 1 or 2");
   end
   if ((RDW_MODE != 0) && (RDW_MODE != 1)) begin : g_bad_rdw
      $error("ram_sdp_param: RDW_MODE must be 0 or 1");
   end
`ifdef RAM_SDP_PARITY_EN
   if (DATA_WIDTH > PARITY_MAX_WIDTH) begin : g_bad_par_width
      $error("ram_sdp_param: DATA_WIDTH exceeds the parity helper width");
   end
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_fire;
   logic                  rd_fire;
   logic                  same_addr;
   logic [DATA_WIDTH-1:0] byte_mask;
   logic [DATA_WIDTH-1:0] wr_word;
   logic [DATA_WIDTH-1:0] rd_word;

   // Requests are only honoured once the clear sequence has finished
   assign wr_fire   = (state_q == READY) && bus.wr_enb;
   assign rd_fire   = (state_q == READY) && bus.rd_enb;
   assign same_addr = wr_fire && (bus.wr_addr == bus.rd_addr);
   assign bus.init_done = (state_q == READY);

   // Controller state and clear counter; reset restarts the clear from word 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // Walk the counter over every word once, then hand over to READY
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ADDR) begin
               state_d    = READY;
               init_cnt_d = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d    = INIT;
            init_cnt_d = '0;
         end
      endcase
   end

   // Expand the byte enables into a bit mask for the write merge
   always_comb begin
      byte_mask = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         byte_mask[8*k +: 8] = {8{bus.wr_be[k]}};
      end
   end

   // Merged word: new bytes where enabled, current contents elsewhere
   assign wr_word = (mem_q[bus.wr_addr] & ~byte_mask) | (bus.wr_data & byte_mask);

   // Read word captured at request time; write-through mode forwards the merge
   always_comb begin
      rd_word = mem_q[bus.rd_addr];
      if ((RDW_MODE == 1) && same_addr) begin
         rd_word = wr_word;
      end
   end

   // Storage: the clear sequence zeroes one word per cycle, READY writes merge
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state_q == INIT) begin
            mem_q[init_cnt_q] <= '0;
         end else if (wr_fire) begin
            mem_q[bus.wr_addr] <= wr_word;
         end
      end
   end

`ifdef RAM_SDP_PARITY_EN
   logic [NUM_BYTES-1:0] par_q [DEPTH];
   logic [NUM_BYTES-1:0] wr_par_new;
   logic [NUM_BYTES-1:0] wr_par_word;
   logic [NUM_BYTES-1:0] rd_par_word;
   logic                 rd_err_word;

   // Parity of the incoming bytes, inverted on request to plant an error
   always_comb begin
      wr_par_new = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         wr_par_new[k] = (^bus.wr_data[8*k +: 8]) ^ bus.wr_par_inj;
      end
   end

   assign wr_par_word = (par_q[bus.wr_addr] & ~bus.wr_be) | (wr_par_new & bus.wr_be);
   assign rd_par_word = ((RDW_MODE == 1) && same_addr) ? wr_par_word : par_q[bus.rd_addr];
   assign rd_err_word = |(byte_parity(PARITY_MAX_WIDTH'(rd_word)) ^ PARITY_MAX_BYTES'(rd_par_word));

   // Parity storage follows the data array; zero data has zero parity
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state_q == INIT) begin
            par_q[init_cnt_q] <= '0;
         end else if (wr_fire) begin
            par_q[bus.wr_addr] <= wr_par_word;
         end
      end
   end
`endif

   ram_sdp_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .RD_LAT     (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
`ifdef RAM_SDP_PARITY_EN
      .err_i   (rd_err_word),
      .err_o   (bus.rd_err),
`endif
      .valid_i (rd_fire),
      .data_i  (rd_word),
      .valid_o (bus.rd_valid),
      .data_o  (bus.rd_data)
   );

endmodule

// File: tb/tb_ram_sdp_param.sv
// Scoreboard bench for ram_sdp_param. Two instances share one stimulus
// stream: dut0 with RD_LAT=1/RDW_MODE=0 and dut1 with RD_LAT=2/RDW_MODE=1.
// Parity checks are included when RAM_SDP_PARITY_EN is defined.
module tb_ram_sdp_param;

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wrEnb = 1'b0;
   logic [4:0]  wrAddr = '0;
   logic [15:0] wrData = '0;
   logic [1:0]  wrBe = '0;
   logic        rdEnb = 1'b0;
   logic [4:0]  rdAddr = '0;
   logic        parInj = 1'b0;

   int checkCount = 0;
   int failCount = 0;
   int cyc = 0;
   bit modelReady = 1'b0;

   logic [15:0] modelMem [32];
   logic [1:0]  modelBad [32];
   exp_t q0[$];
   exp_t q1[$];

   ram_sdp_param_if #(.DATA_WIDTH(16), .DEPTH(32)) bus0 ();
   ram_sdp_param_if #(.DATA_WIDTH(16), .DEPTH(32)) bus1 ();

   assign bus0.wr_enb  = wrEnb;
   assign bus0.wr_addr = wrAddr;
   assign bus0.wr_data = wrData;
   assign bus0.wr_be   = wrBe;
   assign bus0.rd_enb  = rdEnb;
   assign bus0.rd_addr = rdAddr;
   assign bus1.wr_enb  = wrEnb;
   assign bus1.wr_addr = wrAddr;
   assign bus1.wr_data = wrData;
   assign bus1.wr_be   = wrBe;
   assign bus1.rd_enb  = rdEnb;
   assign bus1.rd_addr = rdAddr;
`ifdef RAM_SDP_PARITY_EN
   assign bus0.wr_par_inj = parInj;
   assign bus1.wr_par_inj = parInj;
`endif

   ram_sdp_param #(.DATA_WIDTH(16), .DEPTH(32), .RD_LAT(1), .RDW_MODE(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   ram_sdp_param #(.DATA_WIDTH(16), .DEPTH(32), .RD_LAT(2), .RDW_MODE(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // Free-running clock and a cycle counter used to time read results
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every comparison funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic logic [15:0] mergeWord(input logic [15:0] old, input logic [15:0] data, input logic [1:0] be);
      logic [15:0] r;
      r = old;
      for (int k = 0; k < 2; k++) begin
         if (be[k]) r[8*k +: 8] = data[8*k +: 8];
      end
      return r;
   endfunction

   function automatic logic [1:0] mergeBad(input logic [1:0] old, input logic [1:0] be, input logic inj);
      logic [1:0] r;
      r = old;
      for (int k = 0; k < 2; k++) begin
         if (be[k]) r[k] = inj;
      end
      return r;
   endfunction

   // Drive one cycle of requests, queue expected read results, update model
   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                                input logic [1:0] be, input logic re, input logic [4:0] ra,
                                input logic inj);
      exp_t e0;
      exp_t e1;
      wrEnb = we; wrAddr = wa; wrData = wd; wrBe = be;
      rdEnb = re; rdAddr = ra; parInj = inj;
      if (modelReady && re) begin
         e0.data = modelMem[ra];
         e0.err  = |modelBad[ra];
         e0.due  = cyc + 1;
         e1.data = modelMem[ra];
         e1.err  = |modelBad[ra];
         e1.due  = cyc + 2;
         if (we && (wa == ra)) begin
            e1.data = mergeWord(modelMem[ra], wd, be);
            e1.err  = |mergeBad(modelBad[ra], be, inj);
         end
         q0.push_back(e0);
         q1.push_back(e1);
      end
      @(negedge clk);
      if (modelReady && we) begin
         modelMem[wa] = mergeWord(modelMem[wa], wd, be);
         modelBad[wa] = mergeBad(modelBad[wa], be, inj);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b0);
      end
   endtask

   task automatic readAll();
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'(a), 1'b0);
      end
   endtask

   // Release reset and count edges until init_done; optionally pulse reset mid-clear
   task automatic runInit(input int pulseAt, output int lat0, output int lat1);
      int n = 0;
      bit pulsed = 1'b0;
      lat0 = -1;
      lat1 = -1;
      rst = 1'b1;
      while ((lat0 < 0 || lat1 < 0) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bus0.init_done === 1'b1 && lat0 < 0) lat0 = n;
         if (bus1.init_done === 1'b1 && lat1 < 0) lat1 = n;
         @(negedge clk);
         if (pulseAt > 0 && !pulsed && n == pulseAt) begin
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            n = 0;
            pulsed = 1'b1;
         end
      end
      wrEnb = 1'b0; rdEnb = 1'b0; parInj = 1'b0;
      for (int a = 0; a < 32; a++) begin
         modelMem[a] = 16'h0;
         modelBad[a] = 2'b00;
      end
      modelReady = 1'b1;
   endtask

   // dut0 result checker
   always begin : mon0
      exp_t e;
      @(posedge clk);
      #1;
      if (bus0.rd_valid === 1'b1) begin
         if (q0.size() == 0) begin
            checkOutput("d0_unexpected_valid", 32'(bus0.rd_valid), 32'd0);
         end else begin
            e = q0.pop_front();
            checkOutput("d0_rd_data", 32'(bus0.rd_data), 32'(e.data));
            checkOutput("d0_latency", 32'(cyc), 32'(e.due));
`ifdef RAM_SDP_PARITY_EN
            checkOutput("d0_rd_err", 32'(bus0.rd_err), 32'(e.err));
`endif
         end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
         checkOutput("d0_missing_valid", 32'(bus0.rd_valid), 32'd1);
         void'(q0.pop_front());
      end
   end

   // dut1 result checker
   always begin : mon1
      exp_t e;
      @(posedge clk);
      #1;
      if (bus1.rd_valid === 1'b1) begin
         if (q1.size() == 0) begin
            checkOutput("d1_unexpected_valid", 32'(bus1.rd_valid), 32'd0);
         end else begin
            e = q1.pop_front();
            checkOutput("d1_rd_data", 32'(bus1.rd_data), 32'(e.data));
            checkOutput("d1_latency", 32'(cyc), 32'(e.due));
`ifdef RAM_SDP_PARITY_EN
            checkOutput("d1_rd_err", 32'(bus1.rd_err), 32'(e.err));
`endif
         end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
         checkOutput("d1_missing_valid", 32'(bus1.rd_valid), 32'd1);
         void'(q1.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat0;
      int lat1;
      repeat (3) @(negedge clk);
      checkOutput("d0_reset_valid", 32'(bus0.rd_valid), 32'd0);
      checkOutput("d0_reset_data", 32'(bus0.rd_data), 32'd0);
      checkOutput("d0_reset_init_done", 32'(bus0.init_done), 32'd0);
      checkOutput("d1_reset_valid", 32'(bus1.rd_valid), 32'd0);
      checkOutput("d1_reset_data", 32'(bus1.rd_data), 32'd0);
      checkOutput("d1_reset_init_done", 32'(bus1.init_done), 32'd0);

      $display("[TB] init after reset release");
      runInit(0, lat0, lat1);
      checkOutput("d0_init_latency", 32'(lat0), 32'd32);
      checkOutput("d1_init_latency", 32'(lat1), 32'd32);
      readAll();

      $display("[TB] full and partial writes");
      applyStimulus(1'b1, 5'd5, 16'hA5C3, 2'b11, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd5, 1'b0);
      applyStimulus(1'b1, 5'd5, 16'hFFFF, 2'b01, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd5, 1'b0);

      $display("[TB] read during write");
      applyStimulus(1'b1, 5'd9, 16'h1234, 2'b11, 1'b1, 5'd9, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd9, 1'b0);
      applyStimulus(1'b1, 5'd10, 16'hBEEF, 2'b11, 1'b1, 5'd5, 1'b0);
      applyStimulus(1'b1, 5'd5, 16'h1200, 2'b10, 1'b1, 5'd5, 1'b0);
      applyStimulus(1'b1, 5'd5, 16'h0000, 2'b00, 1'b1, 5'd5, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd10, 1'b0);

      $display("[TB] write after read in flight");
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd11, 1'b0);
      applyStimulus(1'b1, 5'd11, 16'h7777, 2'b11, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd11, 1'b0);

`ifdef RAM_SDP_PARITY_EN
      $display("[TB] parity injection");
      applyStimulus(1'b1, 5'd3, 16'h00FF, 2'b11, 1'b0, 5'd0, 1'b1);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3, 1'b0);
      applyStimulus(1'b1, 5'd3, 16'h00FF, 2'b11, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd3, 1'b0);
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 16'($urandom),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 15)), 1'b0);
      end
      idleCycles(4);

      $display("[TB] reset pulse during init with requests held");
      rst = 1'b0;
      modelReady = 1'b0;
      wrEnb = 1'b1; wrAddr = 5'd7; wrData = 16'hFFFF; wrBe = 2'b11;
      rdEnb = 1'b1; rdAddr = 5'd7;
      @(negedge clk);
      runInit(10, lat0, lat1);
      checkOutput("d0_reinit_latency", 32'(lat0), 32'd32);
      checkOutput("d1_reinit_latency", 32'(lat1), 32'd32);
      readAll();
      idleCycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
